pwm_compare_array: RTL and testbench

- Parametrised, multi-channel successor to the 4-bit count/compare block: one shared free-running counter compared against CHANNELS independent programmable thresholds.
- Produces duty-cycle (rate-coded) outputs for driving neuron activation and spike-rate stages.
- Adds a programmable period, count enable, and double-buffered threshold/period updates applied glitch-free at period rollover.

---
 rtl/pwm_compare_array_pkg.sv | 17 +
 rtl/pwm_channel.sv | 60 ++++++
 rtl/pwm_compare_array.sv | 150 +++++++++++++++
 tb/tb_pwm_compare_array.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_compare_array_pkg.sv
// Shared constants and helpers for the pwm_compare_array block.
// Width-generic reset values are held at 32 bits and sliced by each user.
package pwm_compare_array_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;

    // Period resets to all ones, duty resets to zero.
    localparam logic [31:0] PERIOD_RST_ALL = '1;
    localparam logic [31:0] DUTY_RST_ALL   = '0;

    // Low bit index of channel ch inside a packed CHANNELS*width bus.
    function automatic int chan_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One compare channel: shadow duty, active duty and registered compare output.
// The active duty changes only on a period rollover, so an output pulse is
// never cut short or stretched by a mid-period update.
module pwm_channel
    import pwm_compare_array_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             res,
    input  logic             en,
    input  logic             load,
    input  logic             rollover,
    input  logic             pending,
    input  logic             bypass,
    input  logic [WIDTH-1:0] duty_in,
    input  logic [WIDTH-1:0] count,
    output logic             out
);

    localparam logic [WIDTH-1:0] DUTY_RST = DUTY_RST_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             out_q, out_d;

    // Next-state: shadow capture, rollover transfer (or bypass), compare.
    always_comb begin
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        out_d      = out_q;
        if (load) begin
            duty_sh_d = duty_in;
        end
        if (bypass) begin
            duty_act_d = duty_in;
        end else if (rollover && pending) begin
            duty_act_d = duty_sh_q;
        end
        if (en) begin
            out_d = (count < duty_act_q);
        end
    end

    // Channel state registers.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            duty_sh_q  <= DUTY_RST;
            duty_act_q <= DUTY_RST;
            out_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            out_q      <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/pwm_compare_array.sv
// Multi-channel PWM: one shared counter compared against CHANNELS thresholds,
// with double-buffered period/duty updates applied at period rollover.
// Optional macro PWM_CENTER_ALIGNED_EN selects an up/down (centre-aligned)
// counter; without it the counter is edge-aligned and has no direction flop.
module pwm_compare_array
    import pwm_compare_array_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clock,
    input  logic                      res,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]       out,
    output logic [WIDTH-1:0]          count,
    output logic                      wrap
);

    localparam logic [WIDTH-1:0] PERIOD_RST = PERIOD_RST_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_act_q, period_act_d;
    logic [WIDTH-1:0] period_sh_q, period_sh_d;
    logic             pending_q, pending_d;
    logic             wrap_q, wrap_d;
    logic             rollover;
    logic             bypass;

`ifdef PWM_CENTER_ALIGNED_EN
    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    logic [0:0] dir_q, dir_d;

    // Up/down counter; rollover is the step that lands on 0 while descending.
    always_comb begin
        count_d  = count_q;
        dir_d    = dir_q;
        rollover = 1'b0;
        if (en) begin
            if (period_act_q == '0) begin
                rollover = 1'b1;
                count_d  = '0;
                dir_d    = DIR_UP;
            end else if ((dir_q == DIR_DOWN) || (count_q == period_act_q)) begin
                if (count_q <= ONE) begin
                    rollover = 1'b1;
                    count_d  = '0;
                    dir_d    = DIR_UP;
                end else begin
                    count_d = count_q - ONE;
                    dir_d   = DIR_DOWN;
                end
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // Direction register.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Edge-aligned counter: 0..period_act then back to 0.
    always_comb begin
        count_d  = count_q;
        rollover = 1'b0;
        if (en) begin
            if (count_q == period_act_q) begin
                rollover = 1'b1;
                count_d  = '0;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end
`endif

    // A load on the rollover edge goes straight to the active registers.
    assign bypass = load && rollover;

    // Period double buffer, pending flag and wrap pulse (0 whenever en is low).
    always_comb begin
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        pending_d    = pending_q;
        wrap_d       = rollover;
        if (load) begin
            period_sh_d = period_in;
        end
        if (bypass) begin
            period_act_d = period_in;
            pending_d    = 1'b0;
        end else if (rollover) begin
            if (pending_q) begin
                period_act_d = period_sh_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Shared counter and control registers.
    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            count_q      <= '0;
            period_act_q <= PERIOD_RST;
            period_sh_q  <= PERIOD_RST;
            pending_q    <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            period_act_q <= period_act_d;
            period_sh_q  <= period_sh_d;
            pending_q    <= pending_d;
            wrap_q       <= wrap_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clock    (clock),
            .res      (res),
            .en       (en),
            .load     (load),
            .rollover (rollover),
            .pending  (pending_q),
            .bypass   (bypass),
            .duty_in  (duty_in[chan_lo(i, WIDTH) +: WIDTH]),
            .count    (count_q),
            .out      (out[i])
        );
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_pwm_compare_array.sv
// Directed bench for pwm_compare_array (WIDTH=4, CHANNELS=2, edge mode).
module tb_pwm_compare_array;

    logic       clock = 1'b0;
    logic       res;
    logic       en;
    logic       load;
    logic [3:0] period_in;
    logic [7:0] duty_in;
    logic [1:0] out;
    logic [3:0] count;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       en;
        logic       load;
        logic [3:0] period;
        logic [3:0] d1;
        logic [3:0] d0;
        logic [3:0] cnt;
        logic [1:0] outv;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    pwm_compare_array #(
        .WIDTH    (4),
        .CHANNELS (2)
    ) dut (
        .clock     (clock),
        .res       (res),
        .en        (en),
        .load      (load),
        .period_in (period_in),
        .duty_in   (duty_in),
        .out       (out),
        .count     (count),
        .wrap      (wrap)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic l, input logic [3:0] p,
                       input logic [3:0] d1, input logic [3:0] d0,
                       input logic [3:0] c, input logic [1:0] o, input logic w);
        vec_t v;
        v.en = e; v.load = l; v.period = p; v.d1 = d1; v.d0 = d0;
        v.cnt = c; v.outv = o; v.wrap = w;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;

        // Table starts at the first wrap after period=9, duty={7,3} is active.
        // A: one full 10-cycle period, out0 high 3/10, out1 high 7/10.
        add(1,0,9,7,3, 1,2'b11,0); add(1,0,9,7,3, 2,2'b11,0);
        add(1,0,9,7,3, 3,2'b11,0); add(1,0,9,7,3, 4,2'b10,0);
        add(1,0,9,7,3, 5,2'b10,0); add(1,0,9,7,3, 6,2'b10,0);
        add(1,0,9,7,3, 7,2'b10,0); add(1,0,9,7,3, 8,2'b00,0);
        add(1,0,9,7,3, 9,2'b00,0); add(1,0,9,7,3, 0,2'b00,1);
        // B: load ch0=5 at count=4; old pattern until the wrap, then 5/10.
        add(1,0,9,7,3, 1,2'b11,0); add(1,0,9,7,3, 2,2'b11,0);
        add(1,0,9,7,3, 3,2'b11,0); add(1,0,9,7,3, 4,2'b10,0);
        add(1,1,9,7,5, 5,2'b10,0); add(1,0,9,7,5, 6,2'b10,0);
        add(1,0,9,7,5, 7,2'b10,0); add(1,0,9,7,5, 8,2'b00,0);
        add(1,0,9,7,5, 9,2'b00,0); add(1,0,9,7,5, 0,2'b00,1);
        add(1,0,9,7,5, 1,2'b11,0); add(1,0,9,7,5, 2,2'b11,0);
        add(1,0,9,7,5, 3,2'b11,0); add(1,0,9,7,5, 4,2'b11,0);
        add(1,0,9,7,5, 5,2'b11,0); add(1,0,9,7,5, 6,2'b10,0);
        add(1,0,9,7,5, 7,2'b10,0); add(1,0,9,7,5, 8,2'b00,0);
        add(1,0,9,7,5, 9,2'b00,0);
        // C: load period=5 exactly on the rollover edge; next wrap 6 later.
        add(1,1,5,7,5, 0,2'b00,1); add(1,0,5,7,5, 1,2'b11,0);
        add(1,0,5,7,5, 2,2'b11,0); add(1,0,5,7,5, 3,2'b11,0);
        add(1,0,5,7,5, 4,2'b11,0); add(1,0,5,7,5, 5,2'b11,0);
        add(1,0,5,7,5, 0,2'b10,1); add(1,0,5,7,5, 1,2'b11,0);
        // D: duty ch0=0 (never high), ch1=15 > period 9 (always high).
        add(1,1,9,15,0, 2,2'b11,0); add(1,0,9,15,0, 3,2'b11,0);
        add(1,0,9,15,0, 4,2'b11,0); add(1,0,9,15,0, 5,2'b11,0);
        add(1,0,9,15,0, 0,2'b10,1);
        for (int k = 1; k <= 9; k++) add(1,0,9,15,0, 4'(k),2'b10,0);
        add(1,0,9,15,0, 0,2'b10,1); add(1,0,9,15,0, 1,2'b10,0);
        // E: period=0 -> count stuck at 0, wrap held high, out = duty!=0.
        add(1,1,0,0,3, 2,2'b10,0);
        for (int k = 3; k <= 9; k++) add(1,0,0,0,3, 4'(k),2'b10,0);
        add(1,0,0,0,3, 0,2'b10,1);
        add(1,0,0,0,3, 0,2'b01,1); add(1,0,0,0,3, 0,2'b01,1);
        add(1,0,0,0,3, 0,2'b01,1);
        // F: restore period=9 duty={7,3} (bypass), then en low 4 cycles at 6.
        add(1,1,9,7,3, 0,2'b01,1); add(1,0,9,7,3, 1,2'b11,0);
        add(1,0,9,7,3, 2,2'b11,0); add(1,0,9,7,3, 3,2'b11,0);
        add(1,0,9,7,3, 4,2'b10,0); add(1,0,9,7,3, 5,2'b10,0);
        add(1,0,9,7,3, 6,2'b10,0);
        for (int k = 0; k < 4; k++) add(0,0,9,7,3, 6,2'b10,0);
        add(1,0,9,7,3, 7,2'b10,0);
        // G: pending load of duty {1,1} at count 7, reset follows at count 8.
        add(1,1,9,1,1, 8,2'b00,0);

        res = 1'b1; en = 1'b0; load = 1'b0; period_in = '0; duty_in = '0;
        tick();
        tick();
        chk("reset_count", 32'(count), 0);
        chk("reset_out", 32'(out), 0);
        chk("reset_wrap", 32'(wrap), 0);

        res = 1'b0;
        en = 1'b0; load = 1'b1; period_in = 4'd9; duty_in = {4'd7, 4'd3};
        tick();
        chk("load_en_low_count", 32'(count), 0);
        chk("load_en_low_wrap", 32'(wrap), 0);

        // Pending load must take effect at the rollover of the reset period (15).
        load = 1'b0; en = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!wrap && n < 40);
        chk("first_wrap_cycles", 32'(n), 16);
        chk("first_wrap_count", 32'(count), 0);
        chk("first_wrap_out", 32'(out), 0);

        foreach (vecs[i]) begin
            en        = vecs[i].en;
            load      = vecs[i].load;
            period_in = vecs[i].period;
            duty_in   = {vecs[i].d1, vecs[i].d0};
            tick();
            chk($sformatf("row%0d_count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("row%0d_out", i), 32'(out), 32'(vecs[i].outv));
            chk($sformatf("row%0d_wrap", i), 32'(wrap), 32'(vecs[i].wrap));
        end

        // Asynchronous reset mid-period with a load still pending.
        load = 1'b0;
        #2 res = 1'b1;
        #1;
        chk("async_reset_count", 32'(count), 0);
        chk("async_reset_out", 32'(out), 0);
        chk("async_reset_wrap", 32'(wrap), 0);
        tick();
        res = 1'b0; en = 1'b1;

        // Reset period 15, duty 0: the discarded {1,1} must never appear.
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("post_reset%0d_count", k), 32'(count), 32'(k % 16));
            chk($sformatf("post_reset%0d_out", k), 32'(out), 0);
            chk($sformatf("post_reset%0d_wrap", k), 32'(wrap), (k == 16) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
